// File: rtl/bnn_vote_accumulator.sv
// Per-window vote accumulator and sequential argmax for the BNN core's final layer.
// Optional macro BNN_VOTE_TIE_EN adds the out_tie output and its tracking logic.
module bnn_vote_accumulator #(
  parameter int NUM_CLASSES = 4,
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 16,
  localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ena,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [NUM_CLASSES-1:0] in_bits,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_class,
  output logic [CNT_W-1:0]       out_count,
  output logic                   busy
`ifdef BNN_VOTE_TIE_EN
  ,
  output logic                   out_tie
`endif
);

  // state   | meaning
  // ACCUM   | accepting samples into the vote counters
  // RESOLVE | scanning one class per cycle for the maximum
  // HOLD    | result presented, waiting for out_ready
  typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
  logic [15:0]      samp_q, samp_d;
  logic [IDX_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d, nxt_idx;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d, nxt_cnt;
  logic [IDX_W-1:0] cls_q, cls_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
`ifdef BNN_VOTE_TIE_EN
  logic             best_tie_q, best_tie_d, nxt_tie;
  logic             tie_q, tie_d;
`endif

  // One step of the argmax: strict compare keeps ties on the lowest index.
  always_comb begin
    nxt_idx = best_idx_q;
    nxt_cnt = best_cnt_q;
`ifdef BNN_VOTE_TIE_EN
    nxt_tie = best_tie_q;
`endif
    if (scan_q == '0) begin
      nxt_idx = '0;
      nxt_cnt = cnt_q[0];
`ifdef BNN_VOTE_TIE_EN
      nxt_tie = 1'b0;
`endif
    end else if (cnt_q[scan_q] > best_cnt_q) begin
      nxt_idx = scan_q;
      nxt_cnt = cnt_q[scan_q];
`ifdef BNN_VOTE_TIE_EN
      nxt_tie = 1'b0;
    end else if (cnt_q[scan_q] == best_cnt_q) begin
      nxt_tie = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    samp_d     = samp_q;
    scan_d     = scan_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    cls_d      = cls_q;
    count_d    = count_q;
    valid_d    = valid_q;
`ifdef BNN_VOTE_TIE_EN
    best_tie_d = best_tie_q;
    tie_d      = tie_q;
`endif
    if (ena) begin
      if (clear) begin
        state_d    = ACCUM;
        cnt_d      = '{default: '0};
        samp_d     = '0;
        scan_d     = '0;
        best_idx_d = '0;
        best_cnt_d = '0;
        cls_d      = '0;
        count_d    = '0;
        valid_d    = 1'b0;
`ifdef BNN_VOTE_TIE_EN
        best_tie_d = 1'b0;
        tie_d      = 1'b0;
`endif
      end else begin
        case (state_q)
          ACCUM: begin
            if (in_valid) begin
              for (int c = 0; c < NUM_CLASSES; c++) begin
                if (in_bits[c] && (cnt_q[c] != '1)) cnt_d[c] = cnt_q[c] + CNT_W'(1);
              end
              samp_d = samp_q + 16'd1;
              if (samp_q == 16'(WINDOW - 1)) begin
                state_d = RESOLVE;
                scan_d  = '0;
              end
            end
          end
          RESOLVE: begin
            best_idx_d = nxt_idx;
            best_cnt_d = nxt_cnt;
`ifdef BNN_VOTE_TIE_EN
            best_tie_d = nxt_tie;
`endif
            if (scan_q == IDX_W'(NUM_CLASSES - 1)) begin
              state_d = HOLD;
              cls_d   = nxt_idx;
              count_d = nxt_cnt;
              valid_d = 1'b1;
`ifdef BNN_VOTE_TIE_EN
              tie_d   = nxt_tie;
`endif
            end else begin
              scan_d = scan_q + IDX_W'(1);
            end
          end
          HOLD: begin
            if (out_ready) begin
              state_d = ACCUM;
              cnt_d   = '{default: '0};
              samp_d  = '0;
              valid_d = 1'b0;
            end
          end
          default: state_d = ACCUM;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ACCUM;
      cnt_q      <= '{default: '0};
      samp_q     <= '0;
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      cls_q      <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
`ifdef BNN_VOTE_TIE_EN
      best_tie_q <= 1'b0;
      tie_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      cls_q      <= cls_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
`ifdef BNN_VOTE_TIE_EN
      best_tie_q <= best_tie_d;
      tie_q      <= tie_d;
`endif
    end
  end

  assign in_ready  = ena && (state_q == ACCUM);
  assign out_valid = valid_q;
  assign out_class = cls_q;
  assign out_count = count_q;
  assign busy      = (state_q != ACCUM) || (samp_q != '0);
`ifdef BNN_VOTE_TIE_EN
  assign out_tie   = tie_q;
`endif

endmodule

// File: tb/tb_bnn_vote_accumulator.sv
// Directed bench: a window-level vote model checks instance A every cycle; instance B covers saturation.
module tb_bnn_vote_accumulator;
  localparam int NC = 4;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic reset, ena, clear;
  logic in_valid, out_ready;
  logic [NC-1:0] in_bits;
  logic a_in_ready, a_out_valid, a_busy;
  logic [1:0] a_out_class;
  logic [7:0] a_out_count;
  logic b_in_valid, b_out_ready;
  logic [NC-1:0] b_in_bits;
  logic b_in_ready, b_out_valid, b_busy;
  logic [1:0] b_out_class;
  logic [1:0] b_out_count;
`ifdef BNN_VOTE_TIE_EN
  logic a_out_tie, b_out_tie;
`endif

  int tests = 0;
  int fails = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  bnn_vote_accumulator #(.NUM_CLASSES(NC), .CNT_W(8), .WINDOW(W)) dut_a (
    .clk(clk), .reset(reset), .ena(ena), .clear(clear),
    .in_valid(in_valid), .in_bits(in_bits), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_class(a_out_class), .out_count(a_out_count), .busy(a_busy)
`ifdef BNN_VOTE_TIE_EN
    , .out_tie(a_out_tie)
`endif
  );

  bnn_vote_accumulator #(.NUM_CLASSES(NC), .CNT_W(2), .WINDOW(6)) dut_b (
    .clk(clk), .reset(reset), .ena(ena), .clear(clear),
    .in_valid(b_in_valid), .in_bits(b_in_bits), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_class(b_out_class), .out_count(b_out_count), .busy(b_busy)
`ifdef BNN_VOTE_TIE_EN
    , .out_tie(b_out_tie)
`endif
  );

  // Window-level model of instance A
  int m_cnt[NC];
  int m_samp, m_phase, m_left, m_class, m_count;
  bit m_tie, m_valid;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) m_cnt[c] = 0;
    m_samp = 0; m_phase = 0; m_left = 0;
    m_class = 0; m_count = 0; m_tie = 1'b0; m_valid = 1'b0;
  endfunction

  function automatic void model_decide();
    int best, nmax;
    best = 0;
    for (int c = 1; c < NC; c++) if (m_cnt[c] > m_cnt[best]) best = c;
    nmax = 0;
    for (int c = 0; c < NC; c++) if (m_cnt[c] == m_cnt[best]) nmax++;
    m_class = best; m_count = m_cnt[best]; m_tie = (nmax > 1); m_valid = 1'b1;
  endfunction

  function automatic void model_step();
    if (reset) begin model_reset(); return; end
    if (!ena) return;
    if (clear) begin model_reset(); return; end
    case (m_phase)
      0: if (in_valid) begin
        for (int c = 0; c < NC; c++) if (in_bits[c] && m_cnt[c] < 255) m_cnt[c]++;
        m_samp++;
        if (m_samp == W) begin m_phase = 1; m_left = NC; end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin model_decide(); m_phase = 2; end
      end
      default: if (out_ready) begin
        for (int c = 0; c < NC; c++) m_cnt[c] = 0;
        m_samp = 0; m_phase = 0; m_valid = 1'b0;
      end
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("in_ready", a_in_ready, int'(ena && m_phase == 0));
      chk("out_valid", a_out_valid, m_valid);
      chk("out_class", a_out_class, m_class);
      chk("out_count", a_out_count, m_count);
      chk("busy", a_busy, int'(m_phase != 0 || m_samp != 0));
`ifdef BNN_VOTE_TIE_EN
      chk("out_tie", a_out_tie, m_tie);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [NC-1:0] bits);
    in_valid = 1'b1; in_bits = bits;
    step();
    in_valid = 1'b0; in_bits = '0;
  endtask

  task automatic wait_hold();
    for (int i = 0; i < 20 && !a_out_valid; i++) step();
    chk("hold_reached", a_out_valid, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ena = 1'b1; clear = 1'b0;
    in_valid = 1'b0; in_bits = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_bits = '0; b_out_ready = 1'b0;
    model_reset();
    run_chk = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_out_count", a_out_count, 0);

    // Four votes for class 1 and the exact latency to out_valid
    repeat (4) send(4'b0010);
    step(); step(); step();
    chk("lat_early", a_out_valid, 0);
    step();
    chk("lat_valid", a_out_valid, 1);
    chk("basic_class", a_out_class, 1);
    chk("basic_count", a_out_count, 4);
    handshake();
    chk("hs_valid_low", a_out_valid, 0);
    chk("hs_in_ready", a_in_ready, 1);

    // Two-way tie resolves to the lower index
    send(4'b0011); send(4'b0011); send(4'b0100); send(4'b1000);
    wait_hold();
    chk("tie_class", a_out_class, 0);
    chk("tie_count", a_out_count, 2);
`ifdef BNN_VOTE_TIE_EN
    chk("tie_flag", a_out_tie, 1);
`endif
    handshake();
    repeat (4) send(4'b0000);
    wait_hold();
    chk("zero_class", a_out_class, 0);
    chk("zero_count", a_out_count, 0);
`ifdef BNN_VOTE_TIE_EN
    chk("zero_tie", a_out_tie, 1);
`endif
    handshake();

    // Backpressure in HOLD with in_valid toggling
    send(4'b0100); send(4'b0100); send(4'b1100); send(4'b0001);
    wait_hold();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_bits = 4'b1111;
      step();
      chk("bp_in_ready", a_in_ready, 0);
    end
    in_valid = 1'b0; in_bits = '0;
    chk("bp_class", a_out_class, 2);
    chk("bp_count", a_out_count, 3);
    handshake();
    repeat (4) send(4'b1000);
    wait_hold();
    chk("bp_next_class", a_out_class, 3);
    chk("bp_next_count", a_out_count, 4);
    handshake();

    // Abort: clear beats a coincident accept, then clear in HOLD beats a handshake
    send(4'b0001); send(4'b0001);
    clear = 1'b1; in_valid = 1'b1; in_bits = 4'b0001;
    step();
    clear = 1'b0; in_valid = 1'b0; in_bits = '0;
    chk("clr_busy", a_busy, 0);
    repeat (4) send(4'b1000);
    wait_hold();
    chk("abort_class", a_out_class, 3);
    chk("abort_count", a_out_count, 4);
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0; out_ready = 1'b0;
    chk("clr_hold_valid", a_out_valid, 0);
    chk("clr_hold_class", a_out_class, 0);

    // Asynchronous reset while holding a result
    repeat (4) send(4'b1000);
    wait_hold();
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_valid", a_out_valid, 0);
    chk("async_rst_busy", a_busy, 0);
    step();
    reset = 1'b0;

    // Enable low freezes accept, scan and handshake
    send(4'b0110); send(4'b0110);
    ena = 1'b0; in_valid = 1'b1; in_bits = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ena_in_ready", a_in_ready, 0);
    end
    in_valid = 1'b0; in_bits = '0; ena = 1'b1;
    send(4'b0110); send(4'b0110);
    wait_hold();
    chk("ena_class", a_out_class, 1);
    chk("ena_count", a_out_count, 4);
`ifdef BNN_VOTE_TIE_EN
    chk("ena_tie", a_out_tie, 1);
`endif
    ena = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("ena_hold_valid", a_out_valid, 1);
    ena = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ena_hs_valid", a_out_valid, 0);

    // Saturation on the narrow-counter instance
    b_in_valid = 1'b1; b_in_bits = 4'b1111;
    repeat (6) step();
    b_in_valid = 1'b0; b_in_bits = '0;
    for (int i = 0; i < 20 && !b_out_valid; i++) step();
    chk("sat_valid", b_out_valid, 1);
    chk("sat_class", b_out_class, 0);
    chk("sat_count", b_out_count, 3);
`ifdef BNN_VOTE_TIE_EN
    chk("sat_tie", b_out_tie, 1);
`endif
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    chk("sat_hs_valid", b_out_valid, 0);

    step();
    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
